vrf_burst_master: RTL and testbench

//  Initiator for the vector register file's recv/send ports. Accepts one burst

---
 rtl/vrf_pkg.sv | 26 ++
 rtl/vrf_burst_master_if.sv | 57 +++++
 rtl/vrf_pipe_reg.sv | 47 ++++
 rtl/vrf_burst_master.sv | 127 ++++++++++++
 tb/tb_vrf_burst_master.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vrf_pkg.sv
// Shared constants, FSM state encoding and command layout for the VRF burst master.
package vrf_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 10;
  localparam int LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             write;
    logic [IDX_W-1:0] base;
    logic [LEN_W-1:0] len;
  } cmd_t;

  // Flat VRF index increment; wraps from the top of the index space back to zero.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/vrf_burst_master_if.sv
// Command, write-stream, VRF and read-stream signals of the VRF burst master.
// The master modport is the burst master's view; slave is everything around it.
interface vrf_burst_master_if import vrf_pkg::*; ();

  logic              cmd_val;
  logic              cmd_rdy;
  logic              cmd_write;
  logic [IDX_W-1:0]  cmd_base;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_val;
  logic              wr_rdy;
  logic [DATA_W-1:0] wr_msg;

  logic              vrf_recv_val;
  logic              vrf_recv_rdy;
  logic [IDX_W-1:0]  vrf_recv_index;
  logic [DATA_W-1:0] vrf_recv_msg;
  logic [IDX_W-1:0]  vrf_send_index;
  logic [DATA_W-1:0] vrf_send_msg;

  logic              rd_val;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_msg;

  logic              busy;
  logic              done;

  modport master (
    input  cmd_val, cmd_write, cmd_base, cmd_len,
    output cmd_rdy,
    input  wr_val, wr_msg,
    output wr_rdy,
    output vrf_recv_val, vrf_recv_index, vrf_recv_msg,
    input  vrf_recv_rdy,
    output vrf_send_index,
    input  vrf_send_msg,
    output rd_val, rd_msg,
    input  rd_rdy,
    output busy, done
  );

  modport slave (
    output cmd_val, cmd_write, cmd_base, cmd_len,
    input  cmd_rdy,
    output wr_val, wr_msg,
    input  wr_rdy,
    input  vrf_recv_val, vrf_recv_index, vrf_recv_msg,
    output vrf_recv_rdy,
    input  vrf_send_index,
    output vrf_send_msg,
    input  rd_val, rd_msg,
    output rd_rdy,
    input  busy, done
  );

endinterface

// File: rtl/vrf_pipe_reg.sv
// Single-entry val/rdy register. It accepts new data whenever it is empty or its
// current entry leaves in the same cycle, so a continuously ready sink sees one
// element per cycle.
module vrf_pipe_reg import vrf_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_msg,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_msg
);

  logic              val_q, val_d;
  logic [DATA_W-1:0] msg_q, msg_d;
  logic              load;

  // Load-on-drain: a new entry replaces the old one in the cycle it is consumed.
  always_comb begin
    in_rdy = !val_q || out_rdy;
    load   = in_val && in_rdy;
    val_d  = val_q;
    msg_d  = msg_q;
    if (load) begin
      val_d = 1'b1;
      msg_d = in_msg;
    end else if (out_rdy) begin
      val_d = 1'b0;
    end
  end

  // Entry storage; the message only changes on a load so it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= 1'b0;
      msg_q <= '0;
    end else begin
      val_q <= val_d;
      msg_q <= msg_d;
    end
  end

  assign out_val = val_q;
  assign out_msg = msg_q;

endmodule

// File: rtl/vrf_burst_master.sv
// Burst initiator for the VRF recv/send ports. One command at a time; each burst
// moves one element per cycle between the streams and consecutive VRF indices.
module vrf_burst_master import vrf_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  vrf_burst_master_if.master  bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              last_loaded_q, last_loaded_d;

  logic              cmd_rdy;
  logic              wr_rdy;
  logic              recv_val;
  logic [DATA_W-1:0] recv_msg;
  logic              rd_val;
  logic              done;

  logic              pipe_in_val;
  logic              pipe_in_rdy;
  logic              pipe_out_val;
  logic              pipe_out_rdy;
  logic [DATA_W-1:0] pipe_out_msg;

  assign pipe_out_rdy = (state_q == READ) && bus.rd_rdy;

  vrf_pipe_reg u_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_val  (pipe_in_val),
    .in_rdy  (pipe_in_rdy),
    .in_msg  (bus.vrf_send_msg),
    .out_val (pipe_out_val),
    .out_rdy (pipe_out_rdy),
    .out_msg (pipe_out_msg)
  );

  // Next-state and handshake decode; remaining counts elements left after the current one.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    remaining_d   = remaining_q;
    last_loaded_d = last_loaded_q;
    cmd_rdy       = 1'b0;
    wr_rdy        = 1'b0;
    recv_val      = 1'b0;
    recv_msg      = '0;
    rd_val        = 1'b0;
    pipe_in_val   = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_val) begin
          idx_d         = bus.cmd_base;
          remaining_d   = bus.cmd_len;
          last_loaded_d = 1'b0;
          state_d       = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        recv_val = bus.wr_val;
        wr_rdy   = bus.vrf_recv_rdy;
        recv_msg = bus.wr_msg;
        if (bus.wr_val && bus.vrf_recv_rdy) begin
          idx_d = next_idx(idx_q);
          if (remaining_q == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = LEN_W'(remaining_q - 1'b1);
          end
        end
      end
      READ: begin
        rd_val      = pipe_out_val;
        pipe_in_val = !last_loaded_q;
        if (pipe_in_val && pipe_in_rdy) begin
          idx_d = next_idx(idx_q);
          if (remaining_q == '0) begin
            last_loaded_d = 1'b1;
          end else begin
            remaining_d = LEN_W'(remaining_q - 1'b1);
          end
        end
        if (last_loaded_q && pipe_out_val && bus.rd_rdy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst state registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      remaining_q   <= '0;
      last_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      remaining_q   <= remaining_d;
      last_loaded_q <= last_loaded_d;
    end
  end

  assign bus.cmd_rdy        = cmd_rdy;
  assign bus.wr_rdy         = wr_rdy;
  assign bus.vrf_recv_val   = recv_val;
  assign bus.vrf_recv_msg   = recv_msg;
  assign bus.vrf_recv_index = idx_q;
  assign bus.vrf_send_index = idx_q;
  assign bus.rd_val         = rd_val;
  assign bus.rd_msg         = pipe_out_msg;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = done;

endmodule

// File: tb/tb_vrf_burst_master.sv
// Randomized bench for vrf_burst_master with a VRF memory model and a
// per-burst reference of expected indices and data.
module tb_vrf_burst_master;
  import vrf_pkg::*;

  logic clk;
  logic reset;
  vrf_burst_master_if bus();

  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] wdata [32];
  logic [DATA_W-1:0] expq [32];
  int nchecks;
  int nfails;
  bit aborted;

  vrf_burst_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // VRF read port is combinational from the flat index.
  assign bus.vrf_send_msg = mem[bus.vrf_send_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfails++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of stream inputs. Modes: 0 always ready, 1 random,
  // 2 rd_rdy toggles 1,0,1,0, 3 wr_val gaps with recv_rdy low for 3 cycles.
  task automatic applyStimulus(input bit wr, input int mode, input int cyc,
                               input int fired, input int n, input bit hold);
    bus.cmd_val = hold;
    if (wr) begin
      bus.wr_val       = (mode == 0) ? 1'b1 : (mode == 3) ? (cyc % 3 != 2) : 1'($urandom_range(0, 1));
      bus.wr_msg       = (fired < n) ? wdata[fired] : $urandom;
      bus.vrf_recv_rdy = (mode == 0) ? 1'b1 : (mode == 3) ? !(cyc >= 1 && cyc <= 3) : ($urandom_range(0, 3) != 0);
      bus.rd_rdy       = 1'($urandom_range(0, 1));
    end else begin
      bus.rd_rdy       = (mode == 0) ? 1'b1 : (mode == 2) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.wr_val       = 1'($urandom_range(0, 1));
      bus.wr_msg       = $urandom;
      bus.vrf_recv_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic runBurst(input bit wr, input int base, input int len, input int mode,
                          input bit hold, input bit pre_acc, input int abort_after,
                          output bit was_aborted);
    int n = len + 1;
    int fired = 0;
    int cyc = 0;
    int guard = 0;
    bit finished = 0;
    bit held = 0;
    logic [DATA_W-1:0] held_msg = '0;
    was_aborted = 0;
    for (int i = 0; i < n; i++) begin
      wdata[i] = $urandom;
      expq[i]  = mem[(base + i) % 1024];
    end
    bus.cmd_write = wr;
    bus.cmd_base  = base[IDX_W-1:0];
    bus.cmd_len   = len[LEN_W-1:0];
    if (!pre_acc) begin
      do begin
        @(posedge clk); #1;
        bus.cmd_val = 1'b1;
        @(negedge clk);
        guard++;
      end while (!bus.cmd_rdy && guard < 50);
      if (!bus.cmd_rdy) checkOutput("accept_timeout", 0, 1);
    end
    while (!finished && cyc < 400) begin
      @(posedge clk); #1;
      applyStimulus(wr, mode, cyc, fired, n, hold);
      @(negedge clk);
      if (fired == n) begin
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("busy_in_done", bus.busy, 1);
        checkOutput("cmd_rdy_in_done", bus.cmd_rdy, 0);
        checkOutput("rd_val_in_done", bus.rd_val, 0);
        checkOutput("recv_val_in_done", bus.vrf_recv_val, 0);
        checkOutput("wr_rdy_in_done", bus.wr_rdy, 0);
        finished = 1;
      end else begin
        checkOutput("done_early", bus.done, 0);
        checkOutput("busy", bus.busy, 1);
        checkOutput("cmd_rdy_busy", bus.cmd_rdy, 0);
        if (wr) begin
          checkOutput("recv_val", bus.vrf_recv_val, bus.wr_val);
          checkOutput("wr_rdy", bus.wr_rdy, bus.vrf_recv_rdy);
          checkOutput("recv_index", bus.vrf_recv_index, 64'((base + fired) % 1024));
          checkOutput("rd_val_in_write", bus.rd_val, 0);
          if (bus.vrf_recv_val && bus.vrf_recv_rdy) begin
            checkOutput("recv_msg", bus.vrf_recv_msg, wdata[fired]);
            mem[bus.vrf_recv_index] = bus.vrf_recv_msg;
            fired++;
          end
        end else begin
          checkOutput("recv_val_in_read", bus.vrf_recv_val, 0);
          checkOutput("wr_rdy_in_read", bus.wr_rdy, 0);
          if (cyc == 0) checkOutput("rd_latency_first", bus.rd_val, 0);
          if (cyc == 1) checkOutput("rd_latency_next", bus.rd_val, 1);
          if (held) begin
            checkOutput("rd_val_hold", bus.rd_val, 1);
            checkOutput("rd_msg_hold", bus.rd_msg, held_msg);
          end
          if (bus.rd_val && bus.rd_rdy) begin
            checkOutput("rd_msg", bus.rd_msg, expq[fired]);
            fired++;
          end
          held     = bus.rd_val && !bus.rd_rdy;
          held_msg = bus.rd_msg;
        end
        if (abort_after > 0 && fired == abort_after) begin
          was_aborted = 1;
          return;
        end
      end
      cyc++;
    end
    if (!finished) checkOutput("burst_timeout", 64'(fired), 64'(n));
    @(posedge clk); #1;
    applyStimulus(wr, mode, cyc, n, n, hold);
    @(negedge clk);
    checkOutput("idle_cmd_rdy", bus.cmd_rdy, 1);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_done", bus.done, 0);
    checkOutput("idle_rd_val", bus.rd_val, 0);
    checkOutput("idle_recv_val", bus.vrf_recv_val, 0);
  endtask

  initial begin
    nchecks = 0;
    nfails  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    reset = 1'b1;
    bus.cmd_val = 0; bus.cmd_write = 0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.wr_val = 0; bus.wr_msg = '0; bus.vrf_recv_rdy = 0; bus.rd_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_rdy", bus.cmd_rdy, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_rd_val", bus.rd_val, 0);
    checkOutput("reset_rd_msg", bus.rd_msg, 0);
    checkOutput("reset_recv_index", bus.vrf_recv_index, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] wrap-around write and read-back");
    runBurst(1, 'h3FE, 3, 0, 0, 0, 0, aborted);
    runBurst(0, 'h3FE, 3, 0, 0, 0, 0, aborted);

    $display("[TB] single-element read");
    runBurst(0, 5, 0, 0, 0, 0, 0, aborted);

    $display("[TB] 32-element read with toggling rd_rdy");
    runBurst(0, int'($urandom_range(0, 1023)), 31, 2, 0, 0, 0, aborted);

    $display("[TB] write with gaps and recv stall");
    runBurst(1, 100, 7, 3, 0, 0, 0, aborted);
    runBurst(0, 100, 7, 1, 0, 0, 0, aborted);

    $display("[TB] command held during burst");
    runBurst(0, 200, 4, 1, 1, 0, 0, aborted);
    runBurst(0, 200, 4, 1, 0, 1, 0, aborted);

    $display("[TB] reset mid-read");
    runBurst(0, 300, 31, 1, 0, 0, 10, aborted);
    checkOutput("abort_reached", 64'(aborted), 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rd_val", bus.rd_val, 0);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_cmd_rdy", bus.cmd_rdy, 1);
    checkOutput("async_rd_msg", bus.rd_msg, 0);
    checkOutput("async_send_index", bus.vrf_send_index, 0);
    @(negedge clk);
    bus.cmd_val = 0;
    reset = 1'b0;
    runBurst(1, 300, 5, 1, 0, 0, 0, aborted);
    runBurst(0, 300, 5, 1, 0, 0, 0, aborted);

    $display("[TB] random bursts");
    for (int t = 0; t < 8; t++) begin
      runBurst(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 31)), 1, 0, 0, 0, aborted);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
    $finish;
  end

endmodule
